uart_frame_rx: RTL and testbench

Frame controller that sequences the byte stream from the UART receive path into checked messages. It hunts for a start-of-frame byte, takes a length byte, buffers the payload, and verifies an 8-bit additive checksum. An inter-byte timeout aborts stalled frames. Accepted payloads are then replayed to the application over a valid/ready stream. It sits between the UART byte receiver (rcv/data strobe) and the command decoder.

---
 rtl/uart_frame_rx_if.sv | 28 ++
 rtl/uart_frame_rx.sv | 106 ++++++++++
 tb/tb_uart_frame_rx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// Byte-in / payload-out signal bundle for the UART frame receiver.
// master = the frame receiver, slave = the UART byte source plus command decoder side.
interface uart_frame_rx_if;
    logic       rcv;
    logic [7:0] data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] frame_len;
    logic       busy;
    logic       err_len;
    logic       err_sum;
    logic       err_tmo;
    logic       err_ovr;

    modport master (
        input  rcv, data, out_ready,
        output out_data, out_valid, out_last, frame_len, busy,
        output err_len, err_sum, err_tmo, err_ovr
    );

    modport slave (
        output rcv, data, out_ready,
        input  out_data, out_valid, out_last, frame_len, busy,
        input  err_len, err_sum, err_tmo, err_ovr
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame controller: SOF hunt, length, buffered payload, additive checksum,
// inter-byte timeout, then replays the accepted payload over valid/ready.
module uart_frame_rx #(
    parameter logic [7:0]  SOF     = 8'h7E,
    parameter int          MAX_LEN = 16,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic             clk,
    input  logic             rstn,
    uart_frame_rx_if.master  bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

    state_t          state, state_n;
    logic [7:0]      len, sum;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [15:0]     tmo_cnt;
    logic [7:0]      mem [MAX_LEN];

    logic [7:0]      sum_nx;
    logic            len_bad, timed, tmo_hit, wr_last, rd_last, xfer;

    assign sum_nx  = sum + bus.data;
    assign len_bad = (bus.data == 8'd0) || (bus.data > 8'(MAX_LEN));
    assign timed   = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // A byte on the expiry cycle wins over the timeout.
    assign tmo_hit = timed && !bus.rcv && (tmo_cnt == TIMEOUT - 16'd1);
    assign wr_last = (8'(wr_ptr) == len - 8'd1);
    assign rd_last = (8'(rd_ptr) == len - 8'd1);
    assign xfer    = (state == DRAIN) && bus.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.rcv && bus.data == SOF) state_n = LEN;
            LEN:     if (bus.rcv)       state_n = len_bad ? IDLE : PAYLOAD;
                     else if (tmo_hit)  state_n = IDLE;
            PAYLOAD: if (bus.rcv)       state_n = wr_last ? CSUM : PAYLOAD;
                     else if (tmo_hit)  state_n = IDLE;
            CSUM:    if (bus.rcv)       state_n = (sum_nx == 8'd0) ? DRAIN : IDLE;
                     else if (tmo_hit)  state_n = IDLE;
            DRAIN:   if (xfer && rd_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = 8'd0;
        bus.frame_len = 8'd0;
        bus.busy      = (state != IDLE);
        if (state == DRAIN) begin
            bus.out_valid = 1'b1;
            bus.out_last  = rd_last;
            bus.out_data  = mem[rd_ptr];
            bus.frame_len = len;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len         <= 8'd0;
            sum         <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tmo_cnt     <= 16'd0;
            bus.err_len <= 1'b0;
            bus.err_sum <= 1'b0;
            bus.err_tmo <= 1'b0;
            bus.err_ovr <= 1'b0;
        end else begin
            bus.err_len <= (state == LEN)  && bus.rcv && len_bad;
            bus.err_sum <= (state == CSUM) && bus.rcv && (sum_nx != 8'd0);
            bus.err_tmo <= tmo_hit;
            bus.err_ovr <= (state == DRAIN) && bus.rcv;

            if (!timed || bus.rcv || state_n != state) tmo_cnt <= 16'd0;
            else                                       tmo_cnt <= tmo_cnt + 16'd1;

            if (state == LEN && bus.rcv && !len_bad) begin
                len    <= bus.data;
                sum    <= bus.data;
                wr_ptr <= '0;
            end
            if (state == PAYLOAD && bus.rcv) begin
                sum    <= sum_nx;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == CSUM && bus.rcv) rd_ptr <= '0;
            if (xfer)                     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload store is never cleared; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && bus.rcv) mem[wr_ptr] <= bus.data;
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboarded bench for uart_frame_rx: framing, backpressure, errors, timeout, reset.
module tb_uart_frame_rx;
    localparam logic [7:0]  SOF     = 8'h7E;
    localparam int          MAX_LEN = 16;
    localparam logic [15:0] TIMEOUT = 16'd20;
    localparam int          T       = 20;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic [7:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    uart_frame_rx_if bus();

    uart_frame_rx #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0, n_fail = 0;
    int   n_len = 0, n_sum = 0, n_tmo = 0, n_ovr = 0, n_xfer = 0;
    int   exp_len = 0, exp_sum = 0, exp_tmo = 0, exp_ovr = 0;
    int   ready_mode = 1;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rcv  = 1'b1;
        bus.data = b;
        @(negedge clk);
        bus.rcv  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] pl[$]);
        exp_t e;
        for (int i = 0; i < pl.size(); i++) begin
            e.d = pl[i]; e.last = (i == pl.size() - 1); e.len = 8'(pl.size());
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input bit good);
        logic [7:0] s, cs;
        s = 8'(pl.size());
        send(SOF);
        send(s);
        foreach (pl[i]) begin
            send(pl[i]);
            s = s + pl[i];
        end
        cs = 8'd0 - s;
        if (!good) cs = cs ^ 8'h01;
        else push_exp(pl);
        send(cs);
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (q.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        #2;
        chk("drain_done", q.size(), 0);
        chk("busy_after_drain", bus.busy, 0);
    endtask

    // out_ready driven mid high phase, away from both the DUT edge and the monitor.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ~bus.out_ready;
            endcase
        end
    end

    initial begin
        logic [3:0] pv_err, cur;
        logic       pv_valid, pv_ready;
        logic [7:0] pv_data;
        exp_t       e;
        pv_err = '0; pv_valid = 0; pv_ready = 0; pv_data = '0;
        forever begin
            @(negedge clk); #1;
            if (!rstn) begin
                pv_err = '0; pv_valid = 0; pv_ready = 0;
            end else begin
                cur = {bus.err_len, bus.err_sum, bus.err_tmo, bus.err_ovr};
                if ((cur & pv_err) != 4'd0) chk("err_width", cur & pv_err, 0);
                n_len += int'(cur[3]); n_sum += int'(cur[2]);
                n_tmo += int'(cur[1]); n_ovr += int'(cur[0]);
                if (pv_valid && !pv_ready) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, pv_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_xfer++;
                    if (q.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("out_last", bus.out_last, e.last);
                        chk("frame_len", bus.frame_len, e.len);
                    end
                end
                pv_err = cur; pv_valid = bus.out_valid;
                pv_ready = bus.out_ready; pv_data = bus.out_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        int first, x0;
        bus.rcv = 1'b0; bus.data = 8'd0;
        #1;
        chk("rst_stream", {bus.out_valid, bus.out_last, bus.out_data, bus.frame_len}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", {bus.err_len, bus.err_sum, bus.err_tmo, bus.err_ovr}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Good frame, ready high: one byte per cycle starting right after the checksum.
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 1);
        #1;
        chk("first_valid_latency", bus.out_valid, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("valid_falls", bus.out_valid, 0);
        chk("good_q_empty", q.size(), 0);
        chk("good_busy", bus.busy, 0);

        // Backpressure with toggling ready.
        ready_mode = 2;
        x0 = n_xfer;
        send_frame(pl, 1);
        wait_drain(60);
        chk("bp_xfers", n_xfer - x0, 3);
        ready_mode = 1;

        // Bad checksum, then a good frame carrying SOF-valued payload bytes.
        send(SOF); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
        exp_sum++;
        repeat (3) @(negedge clk);
        chk("err_sum_cnt", n_sum, exp_sum);
        chk("bad_no_out", q.size(), 0);
        pl = {8'h7E, 8'h00, 8'h7E};
        send_frame(pl, 1);
        wait_drain(20);

        // Length errors, then stray bytes that must be ignored.
        send(SOF); send(8'h00);
        send(SOF); send(8'(MAX_LEN + 1));
        send(8'h01); send(8'h02); send(8'h03);
        exp_len += 2;
        repeat (2) @(negedge clk); #2;
        chk("err_len_cnt", n_len, exp_len);
        chk("len_err_busy", bus.busy, 0);

        // Boundary lengths: MAX_LEN and 1.
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
        send_frame(pl, 1);
        wait_drain(40);
        pl = {8'hC3};
        send_frame(pl, 1);
        wait_drain(20);

        // Timeout: err_tmo visible TIMEOUT edges after the edge that took AA.
        send(SOF); send(8'h02); send(8'hAA);
        first = -1;
        for (int k = 1; k <= T + 3; k++) begin
            @(negedge clk); #1;
            if (bus.err_tmo && first < 0) first = k;
        end
        exp_tmo++;
        chk("tmo_delay", first, T);
        chk("tmo_busy", bus.busy, 0);

        // Bytes landing exactly on the expiry cycle must be taken.
        @(negedge clk);
        send(SOF); send(8'h02); send(8'hAA);
        repeat (T - 1) @(negedge clk);
        send(8'hBB);
        pl = {8'hAA, 8'hBB};
        push_exp(pl);
        repeat (T - 1) @(negedge clk);
        send(8'h99);
        wait_drain(20);
        chk("err_tmo_cnt", n_tmo, exp_tmo);

        // Overrun while drain is stalled.
        ready_mode = 0;
        @(negedge clk);
        pl = {8'hC1, 8'hC2, 8'hC3};
        send_frame(pl, 1);
        repeat (3) @(negedge clk);
        send(8'h05);
        exp_ovr++;
        repeat (2) @(negedge clk); #2;
        chk("err_ovr_cnt", n_ovr, exp_ovr);
        chk("ovr_data_held", bus.out_data, 8'hC1);
        ready_mode = 1;
        wait_drain(20);

        // Reset mid-payload.
        @(negedge clk);
        send(SOF); send(8'h04); send(8'h01); send(8'h02);
        rstn = 1'b0;
        #1;
        chk("rstp_busy", bus.busy, 0);
        chk("rstp_out", {bus.out_valid, bus.out_last, bus.out_data, bus.frame_len}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset mid-drain.
        ready_mode = 0;
        @(negedge clk);
        pl = {8'hD1, 8'hD2};
        send_frame(pl, 1);
        repeat (2) @(negedge clk); #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("rstd_out", {bus.out_valid, bus.out_last, bus.out_data, bus.frame_len}, 0);
        chk("rstd_err", {bus.err_len, bus.err_sum, bus.err_tmo, bus.err_ovr}, 0);
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        ready_mode = 1;
        @(negedge clk);
        pl = {8'h5A, 8'hA5, 8'h3C, 8'h01};
        send_frame(pl, 1);
        wait_drain(20);

        repeat (3) @(negedge clk); #2;
        chk("final_len", n_len, exp_len);
        chk("final_sum", n_sum, exp_sum);
        chk("final_tmo", n_tmo, exp_tmo);
        chk("final_ovr", n_ovr, exp_ovr);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
